uart_frame_receiver: RTL
========================

# uart_frame_receiver

Standalone UART receiver that converts a serial line into bytes for the design's host logic. It detects a start bit, samples each bit at its centre, checks the stop bit, and presents each received byte with a one-cycle `rxdone` strobe. It is the far end of the serial link driven by the team's UART transmitter: it connects to the transmitter's `tx` output in loopback benches and to an external pin in the top level.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be even and ≥ 4.
- `DATA_BITS`, default 8: data bits per frame, sent LSB first. Legal range is 5–8.
- `clk` input 1: single system clock. Everything is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rx` input 1: serial line. Asynchronous to `clk`. Idles high.
- `rxout` output DATA_BITS: last correctly framed byte. Holds its value until the next good frame.
- `rxdone` output 1: one-cycle pulse when `rxout` is updated.
- `frame_err` output 1: one-cycle pulse when the stop bit samples low.
- `busy` output 1: high in every state except IDLE.

## Operation
- The `rx` input first passes through a 2-flop synchronizer that resets to 1. All internal logic uses the synchronized copy `rx_s`.
- State machine: IDLE, START, DATA, STOP, RECOVER.
- **IDLE**
  - When `rx_s` = 0: clear the bit counter `cnt` and go to START.
- **START**
  - When `cnt` = CLKS_PER_BIT/2 − 1, sample `rx_s`.
    - If it is 0: clear `cnt`, set bit index = 0, go to DATA.
    - If it is 1: this is a glitch or false start. Go to IDLE with no output pulse.
- **DATA**
  - When `cnt` = CLKS_PER_BIT − 1, sample `rx_s` and shift it into the shift register from the MSB side, so the result is LSB-first.
  - Increment the bit index. After bit DATA_BITS − 1 is sampled, go to STOP.
- **STOP**
  - When `cnt` = CLKS_PER_BIT − 1, sample `rx_s`.
    - If it is 1: load `rxout` from the shift register, pulse `rxdone`, go to IDLE.
    - If it is 0: pulse `frame_err`, leave `rxout` unchanged, go to RECOVER.
- **RECOVER**
  - Wait until `rx_s` = 1, then go to IDLE. This stops a break condition or stuck-low line from re-triggering START.
- `cnt` width is $clog2(CLKS_PER_BIT). It clears on every sample and never wraps past CLKS_PER_BIT − 1.
- Reset values:
  - state = IDLE
  - `rxout` = 0
  - `rxdone` = 0
  - `frame_err` = 0
  - `busy` = 0
  - synchronizer flops = 1
  - `cnt` = 0
  - shift register = 0
- Reset asserted mid-frame aborts the frame immediately. No pulse is produced, and `rxout` returns to 0.

## Timing
- Let T0 be the first cycle in which IDLE sees `rx_s` = 0. This is 2 cycles after the falling edge at the `rx` pin.
- Start sample: T0 + CLKS_PER_BIT/2.
- Data bit i sample: T0 + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT.
- Stop sample: T0 + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT.
- `rxdone` or `frame_err` is high for exactly the one cycle after the stop sample.
  - In that same cycle the state is already IDLE (good frame) or RECOVER (framing error).
  - With defaults, `rxdone` is at T0 + 153.
- A new start bit can be accepted from the cycle after `rxdone`. Back-to-back frames with a single stop bit must be received without loss.
- `rxdone` and `frame_err` never assert in the same cycle.
- `busy` rises in the cycle after T0 and falls in the same cycle as the `rxdone` pulse.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding (IDLE, START, DATA, STOP, RECOVER)
  - default constants CLKS_PER_BIT = 16 and DATA_BITS = 8, shared with the transmitter.
- One sub-module, `uart_sync2`: the 2-flop synchronizer, with reset value as a parameter (1 here). It is reused anywhere an asynchronous input enters the design.
- The counter, shift register and FSM stay in the top module.

## Test plan
- **Single byte:** drive 0xA5 at CLKS_PER_BIT = 16 with 1 stop bit.
  - Required: `rxout` = 0xA5, one `rxdone` pulse at T0 + 153, `frame_err` stays 0.
- **Back-to-back bytes:** drive 0x00, 0xFF, 0x3C with no idle gap between frames.
  - Required: three `rxdone` pulses, with `rxout` = 0x00, then 0xFF, then 0x3C.
- **False start:** pulse `rx` low for 4 cycles, then hold it high.
  - Required: `busy` rises, then returns to 0 by T0 + 9; no `rxdone` and no `frame_err`.
- **Framing error:** drive 0x5A with the stop bit held low and the line then held low for 40 bit times.
  - Required: exactly one `frame_err` pulse, `rxout` keeps its previous value, and no new frame starts until `rx` returns high.
  - A following good frame 0x81 must then give `rxout` = 0x81.
- **Reset mid-frame:** assert `rst` during data bit 3 of frame 0x77, then release it and send 0x12.
  - Required: all outputs are 0 during reset, there is no pulse for 0x77, and the next frame gives `rxout` = 0x12.
- **Loopback:** connect the team transmitter's `tx` to `rx` and send 5 random bytes.
  - Required: each `rxout` equals the transmitted `txin`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default link
// constants used by both the transmitter and the receiver.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        RECOVER
    } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input. The reset value
// is a parameter so an idle-high line does not look like activity out of reset.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            // NOTE: non-blocking keeps these as two distinct stages; blocking would collapse them into one flop.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_frame_receiver.sv
// UART receiver: start-bit detection, centre-of-bit sampling, stop-bit check,
// with a one-cycle rxdone strobe per good byte and frame_err per bad stop bit.
module uart_frame_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rxout,
    output logic                 rxdone,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    uart_state_t          state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] rxout_n;
    logic                 rxdone_n;
    logic                 frame_err_n;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            // NOTE: the shift register is reset as well so a frame aborted by reset leaves no stale bits behind.
            shreg     <= '0;
            rxout     <= '0;
            rxdone    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            rxout     <= rxout_n;
            rxdone    <= rxdone_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can hold a value and infer a latch.
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        shreg_n     = shreg;
        rxout_n     = rxout;
        rxdone_n    = 1'b0;
        frame_err_n = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end

            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        idx_n   = '0;
                        state_n = DATA;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            // Bits arrive LSB first, so shifting in at the MSB leaves bit 0 at the bottom.
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    idx_n   = idx + 1'b1;
                    if (idx == IDX_LAST) state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        rxout_n  = shreg;
                        rxdone_n = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = RECOVER;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            // A held-low line must go high again before another start bit counts.
            RECOVER: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end

            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
